// File: rtl/sync_down_counter.sv
// Synchronous down counter/timer: loads a start value, counts to zero, then stops or reloads.
// Every bit of the count updates on the same clock edge, so the block also works as a cascadable prescaler stage.
module sync_down_counter #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;

    // Decrement that saturates at zero instead of wrapping to all-ones.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = (count_q != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_d = PAUSE;
                    end else if (count_q != '0) begin
                        count_d = sat_dec(count_q);
                        // auto_reload only matters on the 1 -> 0 step.
                        if (count_q == ONE) begin
                            tc_d = 1'b1;
                            if (!auto_reload) begin
                                state_d = DONE;
                            end
                        end
                    end else if (reload_q != '0) begin
                        count_d = reload_q;
                    end else begin
                        state_d = DONE;
                    end
                end
                PAUSE: begin
                    if (en) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (start && (reload_q != '0)) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= RST_COUNT;
            reload_q <= RST_COUNT;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign q    = count_q;
    assign zero = (count_q == '0);
    assign tc   = tc_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Bench for sync_down_counter: a timer-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_sync_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         en = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] q;
    logic         zero, tc, busy;

    int tests = 0;
    int fails = 0;
    bit check_on = 1'b0;

    // Timer-level reference: remaining ticks, reload value, and whether the timer is
    // counting, frozen, or has expired since the last load.
    int m_q = 0, m_rel = 0;
    bit m_counting = 0, m_frozen = 0, m_expired = 0, m_tc = 0;

    sync_down_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .en(en), .auto_reload(auto_reload), .q(q), .zero(zero), .tc(tc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        m_tc = 0;
        if (rst) begin
            m_q = 0; m_rel = 0; m_counting = 0; m_frozen = 0; m_expired = 0;
        end else if (load) begin
            m_q = int'(load_val); m_rel = int'(load_val);
            m_counting = 0; m_frozen = 0; m_expired = 0;
        end else if (!m_counting) begin
            if (start) begin
                if (!m_expired) begin
                    if (m_q > 0) m_counting = 1;
                    else m_expired = 1;
                end else if (m_rel > 0) begin
                    m_q = m_rel;
                    m_counting = 1;
                end
            end
        end else if (m_frozen) begin
            if (en) m_frozen = 0;
        end else if (!en) begin
            m_frozen = 1;
        end else if (m_q == 0) begin
            if (m_rel > 0) m_q = m_rel;
            else begin m_counting = 0; m_expired = 1; end
        end else begin
            m_q = m_q - 1;
            if (m_q == 0) begin
                m_tc = 1;
                if (!auto_reload) begin m_counting = 0; m_expired = 1; end
            end
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            chk("model_q", int'(q), m_q);
            chk("model_zero", int'(zero), int'(m_q == 0));
            chk("model_tc", int'(tc), int'(m_tc));
            chk("model_busy", int'(busy), int'(m_counting));
        end
    end

    int tc_seen = 0;

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            #1;
            if (tc === 1'b1) tc_seen++;
        end
    endtask

    task automatic do_load(input int v);
        load_val = W'(v); load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    int exp_seq [5] = '{4, 3, 2, 1, 0};

    initial begin
        cyc(2);
        check_on = 1'b1;
        rst = 1'b0;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_zero", int'(zero), 1);

        // Reset while counting
        do_load(9);
        en = 1'b1;
        do_start();
        cyc(3);
        chk("midcount_q", int'(q), 6);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_mid_q", int'(q), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_tc", int'(tc), 0);
        cyc(2);
        chk("rst_mid_idle_q", int'(q), 0);

        // One-shot from 5
        en = 1'b0;
        do_load(5);
        chk("os_load_q", int'(q), 5);
        en = 1'b1;
        do_start();
        chk("os_start_q", int'(q), 5);
        chk("os_start_busy", int'(busy), 1);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("os_seq_q", int'(q), exp_seq[i]);
        end
        chk("os_tc_at_zero", int'(tc), 1);
        chk("os_busy_drop", int'(busy), 0);
        cyc(10);
        chk("os_hold_q", int'(q), 0);
        chk("os_tc_count", tc_seen, 1);
        // Restart from DONE reloads from the stored value
        do_start();
        chk("done_restart_q", int'(q), 5);
        chk("done_restart_busy", int'(busy), 1);

        // Auto-reload from 3: period 4
        en = 1'b0;
        do_load(3);
        auto_reload = 1'b1;
        en = 1'b1;
        do_start();
        tc_seen = 0;
        cyc(12);
        chk("ar_tc_count", tc_seen, 3);
        chk("ar_busy", int'(busy), 1);
        chk("ar_q", int'(q), 3);
        auto_reload = 1'b0;

        // Pause at 4
        en = 1'b0;
        do_load(6);
        en = 1'b1;
        do_start();
        cyc(2);
        chk("pause_pre_q", int'(q), 4);
        en = 1'b0;
        cyc(4);
        chk("pause_hold_q", int'(q), 4);
        chk("pause_busy", int'(busy), 1);
        en = 1'b1;
        tc_seen = 0;
        cyc(8);
        chk("pause_end_q", int'(q), 0);
        chk("pause_tc_count", tc_seen, 1);

        // Load beats start while running
        do_load(4);
        do_start();
        cyc(2);
        chk("prio_pre_q", int'(q), 2);
        tc_seen = 0;
        load_val = W'(12); load = 1'b1; start = 1'b1;
        cyc(1);
        load = 1'b0; start = 1'b0;
        chk("prio_q", int'(q), 12);
        chk("prio_busy", int'(busy), 0);
        chk("prio_tc", int'(tc), 0);
        cyc(3);
        chk("prio_idle_q", int'(q), 12);
        chk("prio_tc_count", tc_seen, 0);

        // Start from zero goes straight to DONE
        do_load(0);
        tc_seen = 0;
        do_start();
        chk("zero_start_zero", int'(zero), 1);
        chk("zero_start_busy", int'(busy), 0);
        do_start();
        cyc(2);
        chk("zero_start_tc_count", tc_seen, 0);
        chk("zero_restart_busy", int'(busy), 0);

        // Full-scale one-shot: no wrap
        do_load(15);
        chk("full_load_q", int'(q), 15);
        do_start();
        tc_seen = 0;
        cyc(16);
        chk("full_q", int'(q), 0);
        cyc(6);
        chk("full_hold_q", int'(q), 0);
        chk("full_tc_count", tc_seen, 1);

        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
